// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: state encoding and handshake roles shared by pipeline stage registers
package pipe_skid_reg_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;
    localparam bit ROLE_PRODUCER = 1'b0;
    localparam bit ROLE_CONSUMER = 1'b1;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid buffer; PIPE_FLUSH_EN adds a flush input
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             s_fire, m_fire, load_main, load_skid;

    assign s_fire    = s_valid & s_ready;
    assign m_fire    = m_valid & m_ready;
    assign load_main = (state == ST_TWO) ? m_fire : s_fire & (state == ST_EMPTY | m_fire);
    assign load_skid = (state == ST_ONE) & s_fire & ~m_fire;
    assign m_data    = main_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: state_nxt = s_fire ? ST_ONE : ST_EMPTY;
            ST_ONE:   state_nxt = (s_fire & ~m_fire) ? ST_TWO : (m_fire & ~s_fire) ? ST_EMPTY : ST_ONE;
            default:  state_nxt = m_fire ? ST_ONE : ST_TWO;
        endcase
`ifdef PIPE_FLUSH_EN
        if (flush) state_nxt = ST_EMPTY;
`endif
    end

    always_comb begin
        m_valid = state != ST_EMPTY;
        s_ready = state != ST_TWO;
    end

    // On a drain from TWO the skid entry moves forward; otherwise main takes the new beat
    always_ff @(posedge clk) begin
        if (rst)            main_q <= RST_DATA;
        else if (load_main) main_q <= (state == ST_TWO) ? skid_q : s_data;
    end

    always_ff @(posedge clk) begin
        if (rst)            skid_q <= RST_DATA;
        else if (load_skid) skid_q <= s_data;
    end
endmodule
